// File: rtl/ddr2_tap_cal_seq_0.sv
// DQS-group calibration sequencer: walks the shared tap controller across every DQ bit,
// steering capture data and IDELAY pulses to the selected bit, with a per-bit watchdog.

module ddr2_tap_cal_seq_0_lane (
  input  logic sel_hit,
  input  logic busy,
  input  logic dq,
  input  logic tap_dlyce,
  input  logic tap_dlyinc,
  output logic dq_pick,
  output logic dlyce,
  output logic dlyinc
);
  assign dq_pick = dq & sel_hit;
  assign dlyce   = tap_dlyce  & sel_hit & busy;
  assign dlyinc  = tap_dlyinc & sel_hit & busy;
endmodule

module ddr2_tap_cal_seq_0 #(
  parameter int DQ_WIDTH       = 8,
  parameter int SEL_WIDTH      = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cal_start,
  input  logic [DQ_WIDTH-1:0]  dq_in,
  input  logic                 tap_dlyce,
  input  logic                 tap_dlyinc,
  input  logic                 tap_chan_done,
  output logic                 ctrl_dummyread_start,
  output logic                 dq_data,
  output logic [DQ_WIDTH-1:0]  dlyce,
  output logic [DQ_WIDTH-1:0]  dlyinc,
  output logic [SEL_WIDTH-1:0] bit_sel,
  output logic [DQ_WIDTH-1:0]  bit_done,
  output logic                 cal_busy,
  output logic                 cal_done,
  output logic                 cal_err
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

  state_t              state, state_nxt;
  logic [WD_W-1:0]     wd;
  logic [DQ_WIDTH-1:0] sel_hit;
  logic [DQ_WIDTH-1:0] dq_pick;
  logic                last_bit, wd_exp;

  assign last_bit = (bit_sel == SEL_WIDTH'(DQ_WIDTH-1));
  assign wd_exp   = (wd == WD_W'(TIMEOUT_CYCLES-1));

  genvar i;
  generate
    for (i = 0; i < DQ_WIDTH; i++) begin : g_lane
      assign sel_hit[i] = (bit_sel == SEL_WIDTH'(i));
      ddr2_tap_cal_seq_0_lane u_lane (
        .sel_hit    (sel_hit[i]),
        .busy       (cal_busy),
        .dq         (dq_in[i]),
        .tap_dlyce  (tap_dlyce),
        .tap_dlyinc (tap_dlyinc),
        .dq_pick    (dq_pick[i]),
        .dlyce      (dlyce[i]),
        .dlyinc     (dlyinc[i])
      );
    end
  endgenerate

  assign dq_data = |dq_pick;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;

  // chan_done is tested before the watchdog so a done on the expiry cycle still advances
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (tap_chan_done) begin
          if (last_bit) state_nxt = DONE;
        end else if (wd_exp) begin
          state_nxt = ERR;
        end
      end
      default: if (cal_start) state_nxt = RUN;
    endcase
  end

  always_comb begin
    ctrl_dummyread_start = 1'b0;
    cal_busy             = 1'b0;
    cal_done             = 1'b0;
    cal_err              = 1'b0;
    case (state)
      RUN:  begin ctrl_dummyread_start = 1'b1; cal_busy = 1'b1; end
      DONE: cal_done = 1'b1;
      ERR:  cal_err  = 1'b1;
      default: ;
    endcase
  end

  // bit_sel/bit_done hold on expiry so the failing bit stays visible
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_sel  <= '0;
      bit_done <= '0;
      wd       <= '0;
    end else if (state != RUN) begin
      if (cal_start) begin
        bit_sel  <= '0;
        bit_done <= '0;
        wd       <= '0;
      end
    end else if (tap_chan_done) begin
      bit_done <= bit_done | sel_hit;
      bit_sel  <= last_bit ? '0 : bit_sel + SEL_WIDTH'(1);
      wd       <= '0;
    end else if (!wd_exp) begin
      wd <= wd + WD_W'(1);
    end
  end
endmodule

// File: tb/tb_ddr2_tap_cal_seq_0.sv
// Randomized bench for ddr2_tap_cal_seq_0 against a pass-level behavioural model.

module tb_ddr2_tap_cal_seq_0;
  localparam int DQ = 8;
  localparam int SW = 3;
  localparam int T  = 256;

  logic          clk = 0, reset_n = 0;
  logic          cal_start = 0, tap_dlyce = 0, tap_dlyinc = 0, tap_chan_done = 0;
  logic [DQ-1:0] dq_in = '0;
  logic          ctrl_dummyread_start, dq_data, cal_busy, cal_done, cal_err;
  logic [DQ-1:0] dlyce, dlyinc, bit_done;
  logic [SW-1:0] bit_sel;

  int checks = 0, failures = 0;

  ddr2_tap_cal_seq_0 #(.DQ_WIDTH(DQ), .SEL_WIDTH(SW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n), .cal_start(cal_start), .dq_in(dq_in),
    .tap_dlyce(tap_dlyce), .tap_dlyinc(tap_dlyinc), .tap_chan_done(tap_chan_done),
    .ctrl_dummyread_start(ctrl_dummyread_start), .dq_data(dq_data),
    .dlyce(dlyce), .dlyinc(dlyinc), .bit_sel(bit_sel), .bit_done(bit_done),
    .cal_busy(cal_busy), .cal_done(cal_done), .cal_err(cal_err)
  );

  always #5 clk = ~clk;

  // Model: a pass is "running", has a current bit, a mask of finished bits,
  // and an age = clock edges spent on the current bit.
  logic          m_run, m_done, m_err;
  int            m_sel, m_age;
  logic [DQ-1:0] m_mask;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run <= 0; m_done <= 0; m_err <= 0; m_sel <= 0; m_age <= 0; m_mask <= '0;
    end else if (m_run) begin
      if (tap_chan_done) begin
        m_mask <= m_mask | (DQ'(1) << m_sel);
        m_age  <= 0;
        if (m_sel == DQ-1) begin m_run <= 0; m_done <= 1; m_sel <= 0; end
        else m_sel <= m_sel + 1;
      end else if (m_age + 1 == T) begin
        m_run <= 0; m_err <= 1;
      end else m_age <= m_age + 1;
    end else if (cal_start) begin
      m_run <= 1; m_done <= 0; m_err <= 0; m_sel <= 0; m_age <= 0; m_mask <= '0;
    end
  end

  logic [DQ-1:0] e_ce, e_inc;
  logic          e_dq;
  always @(negedge clk) begin
    e_dq  = dq_in[m_sel];
    e_ce  = (m_run && tap_dlyce)  ? (DQ'(1) << m_sel) : '0;
    e_inc = (m_run && tap_dlyinc) ? (DQ'(1) << m_sel) : '0;
    checks++;
    if ({ctrl_dummyread_start, cal_busy, cal_done, cal_err, bit_sel, bit_done, dq_data, dlyce, dlyinc} !==
        {m_run, m_run, m_done, m_err, SW'(m_sel), m_mask, e_dq, e_ce, e_inc}) begin
      failures++;
      $display("FAIL cycle_cmp t=%0t got start=%b busy=%b done=%b err=%b sel=%0d mask=%h dq=%b ce=%h inc=%h exp start=%b busy=%b done=%b err=%b sel=%0d mask=%h dq=%b ce=%h inc=%h",
        $time, ctrl_dummyread_start, cal_busy, cal_done, cal_err, bit_sel, bit_done, dq_data, dlyce, dlyinc,
        m_run, m_run, m_done, m_err, m_sel, m_mask, e_dq, e_ce, e_inc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic dn, input logic [DQ-1:0] dq, input logic ce, input logic inc);
    @(posedge clk); #1;
    cal_start = st; tap_chan_done = dn; dq_in = dq; tap_dlyce = ce; tap_dlyinc = inc;
  endtask

  task automatic rnd(input logic st, input logic dn);
    drive(st, dn, DQ'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic settle;
    @(negedge clk); #1;
  endtask

  // one bit of the tap-controller model: 39 quiet cycles then done
  task automatic bit_pass;
    for (int k = 0; k < 39; k++) rnd(0, 0);
    rnd(0, 1);
  endtask

  initial begin
    repeat (3) rnd(0, 0);
    settle;
    chk("reset_sel", 32'(bit_sel), 0);
    chk("reset_flags", 32'({ctrl_dummyread_start, cal_busy, cal_done, cal_err}), 0);
    chk("reset_mask", 32'(bit_done), 0);
    #1 reset_n = 1;

    // stray dones in IDLE
    for (int k = 0; k < 4; k++) rnd(0, 1);
    rnd(0, 0); settle;
    chk("idle_stray_busy", 32'(cal_busy), 0);
    chk("idle_stray_sel", 32'(bit_sel), 0);

    // full pass with mid-run restart attempt and steering checks
    rnd(1, 0);
    rnd(0, 0); settle;
    chk("start_busy", 32'({ctrl_dummyread_start, cal_busy}), 32'b11);
    bit_pass; bit_pass;
    for (int k = 0; k < 10; k++) rnd(0, 0);
    rnd(1, 0);
    rnd(0, 0); settle;
    chk("restart_ignored_sel", 32'(bit_sel), 2);
    chk("restart_ignored_mask", 32'(bit_done), 32'h03);
    for (int k = 0; k < 27; k++) rnd(0, 0);
    rnd(0, 1);
    drive(0, 0, 8'b0000_1000, 1, 1); settle;
    chk("steer_sel", 32'(bit_sel), 3);
    chk("steer_dq1", 32'(dq_data), 1);
    chk("steer_ce", 32'(dlyce), 32'h08);
    chk("steer_inc", 32'(dlyinc), 32'h08);
    drive(0, 0, 8'hF7, 1, 1); settle;
    chk("steer_dq0", 32'(dq_data), 0);
    for (int k = 0; k < 37; k++) rnd(0, 0);
    rnd(0, 1);
    for (int b = 4; b < DQ; b++) bit_pass;
    rnd(0, 0); settle;
    chk("pass_done", 32'({cal_done, ctrl_dummyread_start, cal_busy}), 32'b100);
    chk("pass_mask", 32'(bit_done), 32'hFF);
    chk("pass_sel", 32'(bit_sel), 0);

    // restart from DONE, then stall at bit 5 for a timeout
    rnd(1, 0);
    rnd(0, 0); settle;
    chk("redo_clear", 32'({cal_done, bit_done}), 0);
    chk("redo_busy", 32'(cal_busy), 1);
    for (int b = 0; b < 5; b++) bit_pass;
    for (int k = 0; k < 256; k++) rnd(0, 0);
    settle;
    chk("wd_not_yet", 32'(cal_err), 0);
    drive(0, 0, DQ'($urandom), 1, 1); settle;
    chk("wd_err", 32'(cal_err), 1);
    chk("wd_mask", 32'(bit_done), 32'h1F);
    chk("wd_sel", 32'(bit_sel), 5);
    chk("wd_start_low", 32'(ctrl_dummyread_start), 0);
    chk("wd_ce_low", 32'(dlyce), 0);

    // done on the exact expiry cycle wins
    rnd(1, 0);
    for (int k = 0; k < 255; k++) rnd(0, 0);
    rnd(0, 1);
    rnd(0, 0); settle;
    chk("race_no_err", 32'(cal_err), 0);
    chk("race_sel", 32'(bit_sel), 1);

    // async reset mid-run at bit 4
    bit_pass; bit_pass; bit_pass;
    drive(0, 0, '0, 1, 1); settle;
    chk("pre_rst_sel", 32'(bit_sel), 4);
    @(posedge clk); #3;
    reset_n = 0; #1;
    chk("arst_regs", 32'({ctrl_dummyread_start, cal_busy, cal_done, cal_err, bit_sel, bit_done}), 0);
    chk("arst_steer", 32'({dq_data, dlyce, dlyinc}), 0);
    rnd(0, 0); rnd(0, 0);
    #1 reset_n = 1;
    for (int k = 0; k < 3; k++) rnd(0, 1);
    rnd(0, 0); settle;
    chk("post_rst_idle", 32'({cal_busy, bit_sel, bit_done}), 0);
    for (int k = 0; k < 5; k++) rnd(0, 0);
    settle;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ddr2_tap_cal_seq_0.md
# ddr2_tap_cal_seq_0

Per-DQS-group calibration sequencer that drives the per-bit DQ tap calibration controller. It issues and holds the dummy-read start level, steers the selected DQ bit's captured data to the tap controller, and routes the tap controller's IDELAY increment/enable pulses to that bit only. On each `chan_done` it advances the bit select, and it flags completion or timeout to the init/calibration top level. It sits between the DDR2 init state machine and the single shared tap controller of a DQS group.

## Interface
- `DQ_WIDTH`, 8: DQ bits per DQS group (2..16).
- `SEL_WIDTH`, 3: width of bit select; `2**SEL_WIDTH >= DQ_WIDTH`.
- `TIMEOUT_CYCLES`, 1024: max cycles allowed per bit before abort (>= 256).
- `clk`  in  1  calibration clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cal_start`  in  1  one-cycle start pulse from init FSM.
- `dq_in`  in  DQ_WIDTH  captured (rising-edge IDDR) data, one bit per DQ.
- `tap_dlyce`  in  1  IDELAY CE pulse from tap controller.
- `tap_dlyinc`  in  1  IDELAY INC from tap controller.
- `tap_chan_done`  in  1  per-bit done pulse from tap controller.
- `ctrl_dummyread_start`  out  1  level to tap controller and read path; high while calibrating.
- `dq_data`  out  1  `dq_in[bit_sel]`, to tap controller.
- `dlyce`  out  DQ_WIDTH  per-bit IDELAY CE.
- `dlyinc`  out  DQ_WIDTH  per-bit IDELAY INC.
- `bit_sel`  out  SEL_WIDTH  bit under calibration.
- `bit_done`  out  DQ_WIDTH  sticky per-bit completion mask.
- `cal_busy`  out  1  high in RUN.
- `cal_done`  out  1  sticky: all bits calibrated.
- `cal_err`  out  1  sticky: watchdog expired.

## Operation
- States: IDLE, RUN, DONE, ERR. Reset: IDLE, and every registered output is 0 (`bit_sel`=0, `bit_done`=0, `ctrl_dummyread_start`=0, `cal_done`=0, `cal_err`=0).
- IDLE/DONE/ERR + `cal_start` -> RUN. The transition clears `bit_sel`, `bit_done`, `cal_done`, `cal_err`, and the watchdog, and sets `ctrl_dummyread_start`=1.
- RUN + `cal_start`: ignored.
- RUN + `tap_chan_done`, `bit_sel`=k < DQ_WIDTH-1: set `bit_done[k]`, `bit_sel`<=k+1, clear watchdog, stay in RUN.
- RUN + `tap_chan_done`, k = DQ_WIDTH-1: set `bit_done[k]`, `bit_sel`<=0, `ctrl_dummyread_start`<=0, `cal_done`<=1, go to DONE.
- `tap_chan_done` outside RUN: ignored.
- Watchdog: counts each RUN cycle and clears on `tap_chan_done`. When it reaches TIMEOUT_CYCLES-1 without `tap_chan_done`: `ctrl_dummyread_start`<=0, `cal_err`<=1, go to ERR. `bit_sel` and `bit_done` hold for debug. Width is clog2(TIMEOUT_CYCLES).
- `tap_chan_done` and watchdog expiry in the same cycle: `tap_chan_done` wins and no error is raised.
- Combinational steering:
  - `dq_data` = `dq_in[bit_sel]`.
  - `dlyce[i]` = `tap_dlyce` & (i==`bit_sel`) & `cal_busy`.
  - `dlyinc[i]` = `tap_dlyinc` & (i==`bit_sel`) & `cal_busy`.
  - All other bits are 0.
- `cal_busy` = (state==RUN), registered with the state.
- `reset_n` low mid-RUN: asynchronously returns all outputs to reset values. Dropping `ctrl_dummyread_start` forces the tap controller to its idle state.

## Timing
- `cal_start` sampled at edge N -> `ctrl_dummyread_start`=1 and `cal_busy`=1 after edge N. The tap controller's first per-bit calibration state follows 2 cycles later.
- `tap_chan_done` sampled at edge M -> new `bit_sel` valid after edge M. This is 1 cycle before the tap controller re-enters per-bit calibration after its pipe-wait cycle, so `dq_data` reflects the new bit when the tap controller samples its initial data.
- A `tap_dlyce` pulse is routed in the same cycle (zero latency, no register).
- Last `tap_chan_done` at edge M -> `ctrl_dummyread_start`=0 and `cal_done`=1 after edge M.
- Expiry: `cal_err` rises TIMEOUT_CYCLES cycles after the last `tap_chan_done`, or after entry to RUN.

## Test plan
- Reset release, then `cal_start`, with a tap-controller model returning `tap_chan_done` 40 cycles after each bit start -> `bit_sel` steps 0..7, `bit_done` fills LSB-first, `cal_done`=1 and `ctrl_dummyread_start`=0 one cycle after the 8th done.
- Set `bit_sel`=3, drive `dq_in`=8'b0000_1000, pulse `tap_dlyce`=`tap_dlyinc`=1 -> `dq_data`=1, `dlyce`=`dlyinc`=8'h08. Repeat with `dq_in`=8'hF7 -> `dq_data`=0.
- Stall the model at bit 5 with TIMEOUT_CYCLES=256 -> `cal_err`=1 exactly 256 cycles after bit-4 done, `bit_done`=8'h1F, `bit_sel`=5, `ctrl_dummyread_start`=0, `dlyce`=0.
- Drive `tap_chan_done` in the cycle the watchdog hits TIMEOUT_CYCLES-1 -> no `cal_err`, `bit_sel` advances.
- `cal_start` pulse at bit 2 during RUN -> no restart, `bit_sel` unaffected. `cal_start` in DONE -> `cal_done` and `bit_done` clear, new pass starts at bit 0.
- Assert `reset_n` low asynchronously mid-RUN at bit 4 -> all outputs 0 before the next clock edge. Stray `tap_chan_done` pulses in IDLE -> no state change.
